// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// opcodes, register-zero constant, FSM states and the control-output bundle.
package pipe_pkg;

  localparam logic [3:0] OP_MULDIV = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] REG_ZERO  = 4'h0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_STALL = 2'd1,
    MD_ISSUE = 2'd2,
    HALT     = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_hazard;
    logic ifid_flush;
    logic idex_bubble;
    logic halted;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_hazard: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, halted: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_hazard: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b1, halted: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_hazard: 1'b0, ifid_flush: 1'b1,
                                    idex_bubble: 1'b1, halted: 1'b0};
  localparam ctrl_t CTRL_HALT   = '{pc_write: 1'b0, ifid_hazard: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b1, halted: 1'b1};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_hazard: 1'b0, ifid_flush: 1'b1,
                                    idex_bubble: 1'b1, halted: 1'b0};

  // A load in EX feeding either ID source; R0 is hardwired and never conflicts.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [3:0] dest,
                                        input logic [3:0] src_one,
                                        input logic [3:0] src_two);
    return mem_read && (dest != REG_ZERO) && ((dest == src_one) || (dest == src_two));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use and MUL/DIV stalls, branch flush,
// HALT, plus a saturating stall-cycle counter. Control outputs are same-cycle.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter logic [3:0]  MULDIV_OP     = OP_MULDIV,
  parameter logic [3:0]  HALT_OP       = OP_HALT,
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_one,
  input  logic [3:0]       id_two,
  input  logic             ex_mem_read,
  input  logic [3:0]       ex_dest,
  input  logic             br_taken,
  output logic             pc_write,
  output logic             ifid_hazard,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_md_cnt;
  logic [3:0] w_md_cnt_nxt;
  logic       w_load_use;
  logic       w_is_halt_op;
  logic       w_is_muldiv_op;
  logic       w_count_inc;
  ctrl_t      w_ctrl;

  assign w_load_use     = load_use_hit(ex_mem_read, ex_dest, id_one, id_two);
  assign w_is_halt_op   = (id_opcode == HALT_OP);
  assign w_is_muldiv_op = (id_opcode == MULDIV_OP);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next-state logic: branch beats HALT_OP beats load-use beats MUL/DIV
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    if (r_state != HALT) begin
      if (br_taken) begin
        w_state_nxt  = RUN;
        w_md_cnt_nxt = 4'd0;
      end else if (w_is_halt_op) begin
        w_state_nxt  = HALT;
        w_md_cnt_nxt = 4'd0;
      end else begin
        case (r_state)
          RUN: begin
            if (!w_load_use && w_is_muldiv_op) begin
              w_state_nxt  = MD_STALL;
              w_md_cnt_nxt = MD_LOAD;
            end
          end
          MD_STALL: begin
            w_md_cnt_nxt = r_md_cnt - 4'd1;
            if (r_md_cnt == 4'd1) begin
              w_state_nxt = MD_ISSUE;
            end
          end
          MD_ISSUE: begin
            // The MUL/DIV leaves IF/ID here; its opcode must not re-trigger.
            if (!w_load_use) begin
              w_state_nxt = RUN;
            end
          end
          default: begin
            w_state_nxt = r_state;
          end
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    w_ctrl = CTRL_NORMAL;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (r_state == HALT) begin
      w_ctrl = CTRL_HALT;
    end else if (br_taken) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_is_halt_op) begin
      w_ctrl = CTRL_NORMAL;
    end else begin
      case (r_state)
        RUN:      if (w_load_use || w_is_muldiv_op) w_ctrl = CTRL_STALL;
        MD_STALL: w_ctrl = CTRL_STALL;
        MD_ISSUE: if (w_load_use) w_ctrl = CTRL_STALL;
        default:  w_ctrl = CTRL_NORMAL;
      endcase
    end
  end

  assign pc_write    = w_ctrl.pc_write;
  assign ifid_hazard = w_ctrl.ifid_hazard;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_bubble = w_ctrl.idex_bubble;
  assign halted      = w_ctrl.halted;

  // HALT holds IF/ID too, but that is not a stall for performance purposes.
  assign w_count_inc = w_ctrl.ifid_hazard && (r_state != HALT);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_count_inc),
    .o_count (stall_count)
  );

endmodule
